// File: rtl/systolic_stream_ctrl.sv
// Stream controller for the weight-stationary systolic array: loads weights,
// feeds skewed input lanes, and re-aligns the staggered results into Y vectors.
module systolic_stream_ctrl #(
   parameter int M          = 5,
   parameter int N          = 3,
   parameter int K          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_LAT  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       reload_w,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [DATA_WIDTH*K-1:0]    w_row,
   input  logic                       x_valid,
   output logic                       x_ready,
   input  logic [DATA_WIDTH*N-1:0]    x_data,
   output logic [DATA_WIDTH*N*K-1:0]  array_w,
   output logic [DATA_WIDTH*N-1:0]    array_x,
   input  logic [DATA_WIDTH*K-1:0]    array_y,
   output logic                       y_valid,
   output logic [DATA_WIDTH*K-1:0]    y_data,
   output logic                       y_last,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 dbg_state
);
   localparam int DW      = DATA_WIDTH;
   localparam int OUT_LAT = ARRAY_LAT + K + 1;
   localparam int CW      = $clog2(M + 1);
   localparam int RW      = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

   state_t             state, state_n;
   logic [RW-1:0]      row_cnt;
   logic [CW-1:0]      acc_cnt;
   logic [CW-1:0]      inflight;
   logic               w_acc, x_acc, x_last;
   logic [OUT_LAT-1:0] vld_sr, last_sr;

   // Handshakes: a transfer happens on a clock edge where valid && ready are
   // both high; ready depends only on state, never on valid.
   assign w_acc     = w_valid && w_ready;
   assign x_acc     = x_valid && x_ready;
   assign x_last    = x_acc && (acc_cnt == CW'(M - 1));
   assign busy      = (state != IDLE);
   assign dbg_state = state;
   assign y_valid   = vld_sr[OUT_LAT-1];
   assign y_last    = last_sr[OUT_LAT-1];

   always_comb begin
      state_n = state;
      w_ready = 1'b0;
      x_ready = 1'b0;
      case (state)
         IDLE:    if (start) state_n = reload_w ? LOAD_W : STREAM;
         LOAD_W: begin
            w_ready = 1'b1;
            if (w_valid && (row_cnt == RW'(N - 1))) state_n = STREAM;
         end
         STREAM: begin
            x_ready = 1'b1;
            if (x_valid && (acc_cnt == CW'(M - 1))) state_n = DRAIN;
         end
         DRAIN:   if (inflight == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         row_cnt  <= '0;
         acc_cnt  <= '0;
         inflight <= '0;
         done     <= 1'b0;
         array_w  <= '0;
         vld_sr   <= '0;
         last_sr  <= '0;
      end else begin
         state   <= state_n;
         // Registered so the pulse lands in the first IDLE cycle.
         done    <= (state == DRAIN) && (inflight == '0);
         vld_sr  <= {vld_sr[OUT_LAT-2:0], x_acc};
         last_sr <= {last_sr[OUT_LAT-2:0], x_last};
         if (state == IDLE) begin
            row_cnt <= '0;
            acc_cnt <= '0;
         end else begin
            if (w_acc) row_cnt <= row_cnt + 1'b1;
            if (x_acc) acc_cnt <= acc_cnt + 1'b1;
         end
         if (x_acc && !y_valid)      inflight <= inflight + 1'b1;
         else if (!x_acc && y_valid) inflight <= inflight - 1'b1;
         for (int r = 0; r < N; r++) begin
            if (w_acc && (row_cnt == RW'(r))) array_w[r*K*DW +: K*DW] <= w_row;
         end
      end
   end

   // Lane i sits behind i+1 registers so the array sees a diagonal wavefront.
   for (genvar i = 0; i < N; i++) begin : g_skew
      logic [DW-1:0] sr [0:i];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= i; j++) sr[j] <= '0;
         end else begin
            sr[0] <= x_acc ? x_data[i*DW +: DW] : '0;
            for (int j = 1; j <= i; j++) sr[j] <= sr[j-1];
         end
      end
      assign array_x[i*DW +: DW] = sr[i];
   end

   // Lane k arrives k cycles late, so it waits K-1-k cycles to line up.
   for (genvar k = 0; k < K; k++) begin : g_deskew
      localparam int D = K - 1 - k;
      logic [DW-1:0] tail;
      logic [DW-1:0] out_q;
      if (D > 0) begin : g_dly
         logic [DW-1:0] dl [0:D-1];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int j = 0; j < D; j++) dl[j] <= '0;
            end else begin
               dl[0] <= array_y[k*DW +: DW];
               for (int j = 1; j < D; j++) dl[j] <= dl[j-1];
            end
         end
         assign tail = dl[D-1];
      end else begin : g_direct
         assign tail = array_y[k*DW +: DW];
      end
      always_ff @(posedge clk) begin
         if (rst)                     out_q <= '0;
         else if (vld_sr[OUT_LAT-2])  out_q <= tail;
      end
      assign y_data[k*DW +: DW] = out_q;
   end

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Directed/random bench for systolic_stream_ctrl with a stub array that
// returns tagged values at the expected staggered times.
module tb_systolic_stream_ctrl;
   localparam int M = 5, N = 3, K = 4, DW = 8, AL = 3;
   localparam int OUT_LAT = AL + K + 1;
   localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_DRAIN = 3;

   logic              clk = 1'b0;
   logic              rst, start, reload_w, w_valid, x_valid;
   logic              w_ready, x_ready, y_valid, y_last, busy, done;
   logic [DW*K-1:0]   w_row, array_y, y_data;
   logic [DW*N-1:0]   x_data, array_x;
   logic [DW*N*K-1:0] array_w;
   logic [1:0]        dbg_state;

   systolic_stream_ctrl #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ARRAY_LAT(AL)) dut (
      .clk(clk), .rst(rst), .start(start), .reload_w(reload_w),
      .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .array_w(array_w), .array_x(array_x), .array_y(array_y),
      .y_valid(y_valid), .y_data(y_data), .y_last(y_last),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              at;
      logic [DW*K-1:0] d;
      logic            last;
   } yexp_t;

   int                n_vec = 0, n_err = 0;
   int                cyc = 0;
   int                phase = P_IDLE, rows_done = 0, accepted = 0, inflight_m = 0;
   logic [DW*N*K-1:0] w_m = '0;
   logic [DW*K-1:0]   last_y = '0;
   logic              y_now = 1'b0, done_exp = 1'b0;
   yexp_t             exp_q[$];
   logic [DW*N-1:0]   acc_x [int];
   logic [DW-1:0]     stub_v [int];

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock, update the reference model, check every output,
   // then drive the stub array's response for the new cycle.
   task automatic tick();
      bit              acc, wacc, y_prev, last_e;
      logic [DW*K-1:0] d;
      logic [DW*N-1:0] ax, v;
      acc    = !rst && x_valid && (phase == P_STREAM);
      wacc   = !rst && w_valid && (phase == P_LOAD);
      y_prev = y_now;
      @(posedge clk);
      cyc++;
      done_exp = 1'b0;
      if (rst) begin
         phase = P_IDLE; w_m = '0; last_y = '0; inflight_m = 0;
         exp_q.delete(); acc_x.delete(); stub_v.delete();
      end else begin
         case (phase)
            P_IDLE: if (start) begin
               phase = reload_w ? P_LOAD : P_STREAM;
               rows_done = 0; accepted = 0;
            end
            P_LOAD: if (wacc) begin
               w_m[rows_done*K*DW +: K*DW] = w_row;
               rows_done++;
               if (rows_done == N) phase = P_STREAM;
            end
            P_STREAM: if (acc) begin
               acc_x[cyc] = x_data;
               for (int k = 0; k < K; k++) begin
                  d[k*DW +: DW] = 8'(16 * (accepted + 1) + k);
                  stub_v[(cyc + AL + k) * K + k] = d[k*DW +: DW];
               end
               exp_q.push_back('{cyc + OUT_LAT - 1, d, accepted == M - 1});
               accepted++;
               if (accepted == M) phase = P_DRAIN;
            end
            P_DRAIN: if (inflight_m == 0) begin
               phase = P_IDLE; done_exp = 1'b1;
            end
            default: phase = P_IDLE;
         endcase
         inflight_m = inflight_m + int'(acc) - int'(y_prev);
      end
      #1;
      y_now  = (exp_q.size() > 0) && (exp_q[0].at == cyc);
      last_e = 1'b0;
      if (y_now) begin
         last_y = exp_q[0].d;
         last_e = exp_q[0].last;
         void'(exp_q.pop_front());
      end
      chk("y_valid", y_valid, y_now);
      chk("y_data", y_data, last_y);
      chk("y_last", y_last, last_e);
      chk("done", done, done_exp);
      chk("busy", busy, phase != P_IDLE);
      chk("state_idle", dbg_state == 2'd0, phase == P_IDLE);
      chk("w_ready", w_ready, phase == P_LOAD);
      chk("x_ready", x_ready, phase == P_STREAM);
      chk("array_w", array_w, w_m);
      ax = '0;
      for (int i = 0; i < N; i++) begin
         if (acc_x.exists(cyc - i)) begin
            v = acc_x[cyc - i];
            ax[i*DW +: DW] = v[i*DW +: DW];
         end
      end
      chk("array_x", array_x, ax);
      for (int k = 0; k < K; k++) begin
         if (stub_v.exists(cyc * K + k)) array_y[k*DW +: DW] = stub_v[cyc * K + k];
         else                            array_y[k*DW +: DW] = 8'($urandom);
      end
   endtask

   task automatic frame(bit reload, logic [DW*N*K-1:0] w_all, bit directed);
      int sent;
      bit bub;
      start = 1'b1; reload_w = reload;
      tick();
      start = 1'b0; reload_w = 1'b0;
      if (reload) begin
         w_valid = 1'b1;
         for (int r = 0; r < N; r++) begin
            w_row = w_all[r*K*DW +: K*DW];
            tick();
         end
         w_valid = 1'b0; w_row = '0;
      end
      sent = 0;
      bub  = 1'b0;
      while (sent < M) begin
         x_valid  = !bub;
         x_data   = (directed && sent == 0) ? 24'h010203 : 24'($urandom);
         start    = ($urandom_range(0, 3) == 0);
         reload_w = 1'($urandom_range(0, 1));
         tick();
         if (x_valid) sent++;
         bub = directed ? (x_valid && (sent == 2 || sent == 4)) : ($urandom_range(0, 3) == 0);
      end
      x_valid = 1'b0; reload_w = 1'b0;
      for (int i = 0; i < 40 && phase != P_IDLE; i++) begin
         start = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; reload_w = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
      w_row = '0; x_data = '0; array_y = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      frame(1'b1, 96'h020102010102010202010201, 1'b1);
      frame(1'b0, '0, 1'b0);

      // Abort mid-stream: two vectors in, then a 3-cycle reset.
      start = 1'b1;
      tick();
      start = 1'b0;
      x_valid = 1'b1;
      repeat (2) begin
         x_data = 24'($urandom);
         tick();
      end
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0; x_valid = 1'b0;
      repeat (12) tick();

      frame(1'b1, {32'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
      repeat (3) frame(1'b0, '0, 1'b0);
      frame(1'b1, {32'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
      frame(1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
